// File: rtl/ws2812_pixel_streamer_if.sv
// rtl/ws2812_pixel_streamer_if.sv - host write bus, control and pixel stream bundle
//
// Purpose: groups every non-clock/reset signal of ws2812_pixel_streamer.
// Signals:
//   wr_en, wr_addr[ADDR_W], wr_data[24]  host colour RAM write port
//   brightness[8]                        global scale, 255 = unity
//   refresh_req                          single-cycle frame request
//   busy, frame_done                     frame status
//   pix_valid, pix_ready, pix_data[24],
//   pix_last                             GRB pixel stream to the serializer
// Modports:
//   master  the streamer side (drives status and the pixel stream)
//   slave   the host/serializer side
interface ws2812_pixel_streamer_if #(
  parameter int ADDR_W = 4
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [23:0]       wr_data;
  logic [7:0]        brightness;
  logic              refresh_req;
  logic              busy;
  logic              pix_valid;
  logic              pix_ready;
  logic [23:0]       pix_data;
  logic              pix_last;
  logic              frame_done;

  modport master (
    input  wr_en, wr_addr, wr_data, brightness, refresh_req, pix_ready,
    output busy, pix_valid, pix_data, pix_last, frame_done
  );

  modport slave (
    output wr_en, wr_addr, wr_data, brightness, refresh_req, pix_ready,
    input  busy, pix_valid, pix_data, pix_last, frame_done
  );
endinterface

// File: rtl/ws2812_pixel_streamer.sv
// rtl/ws2812_pixel_streamer.sv - colour RAM and scaled GRB pixel streamer for a WS2812 serializer
//
// Purpose: holds NUM_LEDS x 24-bit colours written by the host; on each refresh
// streams them as brightness-scaled {G,R,B} words over valid/ready, then holds
// off for the latch gap before reporting frame_done.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    ws2812_pixel_streamer_if.master (write port, control, pixel stream)
module ws2812_pixel_streamer #(
  parameter int NUM_LEDS        = 8,
  parameter int ADDR_W          = 4,
  parameter int CLK_FRE         = 27_000_000,
  parameter int RESET_GAP_US    = 80,
  parameter int AUTO_REFRESH_HZ = 60
) (
  input  logic                   clk,
  input  logic                   rst_n,
  ws2812_pixel_streamer_if.master bus
);

  localparam int GAP_CYC  = CLK_FRE / 1_000_000 * RESET_GAP_US;
  localparam int GAP_W    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam int AUTO_DIV = (AUTO_REFRESH_HZ > 0) ? CLK_FRE / AUTO_REFRESH_HZ : 1;
  localparam int AUTO_W   = (AUTO_DIV > 1) ? $clog2(AUTO_DIV) : 1;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_LEDS - 1);
  localparam logic [GAP_W-1:0]  GAP_END  = GAP_W'(GAP_CYC - 1);
  localparam logic [AUTO_W-1:0] AUTO_END = AUTO_W'(AUTO_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_SCALE,
    S_PRESENT,
    S_GAP
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [7:0]        bri_q, bri_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [AUTO_W-1:0] auto_q, auto_d;
  logic              pending_q, pending_d;
  logic              pix_valid_q, pix_valid_d;
  logic [23:0]       pix_data_q, pix_data_d;
  logic              pix_last_q, pix_last_d;
  logic              frame_done_q, frame_done_d;

  logic              auto_tick;
  logic              req_any;
  logic              wr_ok;

  // Sized to the full address space so any wr_addr indexes it directly;
  // entries at or above NUM_LEDS are never written or read.
  logic [23:0]       mem_q [2**ADDR_W];
  logic [23:0]       rd_q;

  // c' = (c * (b + 1)) >> 8, so b = 255 passes c through unchanged.
  function automatic logic [7:0] scale_ch(input logic [7:0] c, input logic [7:0] b);
    logic [15:0] p;
    p = 16'(c) * (16'(b) + 16'd1);
    return 8'(p >> 8);
  endfunction

  assign wr_ok = ({1'b0, bus.wr_addr} < (ADDR_W+1)'(NUM_LEDS));

  // Colour RAM: not reset. Both accesses are non-blocking, so a read that
  // collides with a write to the same index returns the old word.
  always_ff @(posedge clk) begin
    if (bus.wr_en && wr_ok) begin
      mem_q[bus.wr_addr] <= bus.wr_data;
    end
    if (state_q == S_READ) begin
      rd_q <= mem_q[idx_q];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      bri_q        <= '0;
      gap_q        <= '0;
      auto_q       <= '0;
      pending_q    <= 1'b0;
      pix_valid_q  <= 1'b0;
      pix_data_q   <= '0;
      pix_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      bri_q        <= bri_d;
      gap_q        <= gap_d;
      auto_q       <= auto_d;
      pending_q    <= pending_d;
      pix_valid_q  <= pix_valid_d;
      pix_data_q   <= pix_data_d;
      pix_last_q   <= pix_last_d;
      frame_done_q <= frame_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    bri_d        = bri_q;
    gap_d        = gap_q;
    auto_d       = auto_q;
    pix_valid_d  = pix_valid_q;
    pix_data_d   = pix_data_q;
    pix_last_d   = pix_last_q;
    frame_done_d = 1'b0;
    auto_tick    = 1'b0;

    // Free-running refresh timer, independent of frame activity.
    if (AUTO_REFRESH_HZ > 0) begin
      if (auto_q == AUTO_END) begin
        auto_d    = '0;
        auto_tick = 1'b1;
      end else begin
        auto_d = auto_q + 1'b1;
      end
    end else begin
      auto_d = '0;
    end

    // A request seen in IDLE starts the frame in the same cycle; anything
    // arriving while busy collapses into a single pending frame.
    req_any   = pending_q | bus.refresh_req | auto_tick;
    pending_d = req_any;

    case (state_q)
      S_IDLE: begin
        if (req_any) begin
          state_d   = S_READ;
          idx_d     = '0;
          bri_d     = bus.brightness;
          pending_d = 1'b0;
        end
      end
      S_READ: begin
        state_d = S_SCALE;
      end
      S_SCALE: begin
        pix_data_d  = {scale_ch(rd_q[15:8],  bri_q),
                       scale_ch(rd_q[23:16], bri_q),
                       scale_ch(rd_q[7:0],   bri_q)};
        pix_last_d  = (idx_q == LAST_IDX);
        pix_valid_d = 1'b1;
        state_d     = S_PRESENT;
      end
      S_PRESENT: begin
        if (bus.pix_ready) begin
          pix_valid_d = 1'b0;
          if (pix_last_q) begin
            state_d = S_GAP;
            gap_d   = '0;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_READ;
          end
        end
      end
      S_GAP: begin
        if (gap_q == GAP_END) begin
          state_d      = S_IDLE;
          frame_done_d = 1'b1;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.busy       = (state_q != S_IDLE);
  assign bus.pix_valid  = pix_valid_q;
  assign bus.pix_data   = pix_data_q;
  assign bus.pix_last   = pix_last_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_ws2812_pixel_streamer.sv
// tb/tb_ws2812_pixel_streamer.sv - directed self-checking bench for ws2812_pixel_streamer
module tb_ws2812_pixel_streamer;

  logic clk;
  logic rst_n;

  ws2812_pixel_streamer_if #(.ADDR_W(4)) bus ();

  ws2812_pixel_streamer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // RAM[i] = 0x112233*i (24-bit) reordered to {G,R,B} at unity brightness.
  logic [23:0] exp_t1 [8] = '{24'h000000, 24'h221133, 24'h442266, 24'h663399,
                              24'h8844CC, 24'hAA55FF, 24'hCD6632, 24'hEF7765};

  logic [23:0] px_q  [$];
  logic        lst_q [$];
  int          gap_meas;
  int          pix_int;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic write_led(input logic [3:0] addr, input logic [23:0] data);
    bus.wr_en   = 1'b1;
    bus.wr_addr = addr;
    bus.wr_data = data;
    @(negedge clk);
    bus.wr_en   = 1'b0;
  endtask

  task automatic pulse_req();
    bus.refresh_req = 1'b1;
    @(negedge clk);
    bus.refresh_req = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int k = 0;
    while (!bus.pix_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    check(tag, bus.pix_valid, 1);
  endtask

  // Collects one frame up to frame_done. Optionally issues extra refresh
  // pulses and one RAM write at a given iteration while the frame runs.
  task automatic wait_frame(input int req_pulses, input int inj_iter,
                            input logic [3:0] inj_addr, input logic [23:0] inj_data);
    int  last_at = -1;
    int  prev_at = -1;
    bit  done    = 1'b0;
    px_q.delete();
    lst_q.delete();
    pix_int  = -1;
    gap_meas = -1;
    for (int i = 0; i < 6000 && !done; i++) begin
      if (bus.pix_valid && bus.pix_ready) begin
        if (prev_at >= 0 && pix_int < 0) pix_int = i - prev_at;
        prev_at = i;
        px_q.push_back(bus.pix_data);
        lst_q.push_back(bus.pix_last);
        if (bus.pix_last) last_at = i;
      end
      if (bus.frame_done) begin
        gap_meas = i - last_at;
        done     = 1'b1;
      end else begin
        bus.refresh_req = (i % 4 == 1) && (i / 4 < req_pulses);
        bus.wr_en       = (i == inj_iter);
        bus.wr_addr     = inj_addr;
        bus.wr_data     = inj_data;
        @(negedge clk);
      end
    end
    bus.refresh_req = 1'b0;
    bus.wr_en       = 1'b0;
    check("frame_done_seen", done, 1);
  endtask

  initial begin
    int cnt;
    bit stable;
    logic [23:0] held;

    rst_n           = 1'b0;
    bus.wr_en       = 1'b0;
    bus.wr_addr     = '0;
    bus.wr_data     = '0;
    bus.brightness  = 8'd255;
    bus.refresh_req = 1'b0;
    bus.pix_ready   = 1'b1;
    repeat (3) @(negedge clk);

    check("rst_busy",       bus.busy,       0);
    check("rst_pix_valid",  bus.pix_valid,  0);
    check("rst_pix_data",   bus.pix_data,   0);
    check("rst_pix_last",   bus.pix_last,   0);
    check("rst_frame_done", bus.frame_done, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // T1: unity brightness, full frame, latency and gap
    for (int i = 0; i < 8; i++) write_led(4'(i), 24'(24'h112233 * i));
    pulse_req();
    check("t1_busy_n1",  bus.busy,      1);
    check("t1_valid_n1", bus.pix_valid, 0);
    @(negedge clk);
    check("t1_valid_n2", bus.pix_valid, 0);
    @(negedge clk);
    check("t1_valid_n3", bus.pix_valid, 1);
    wait_frame(0, -1, 4'd0, 24'd0);
    check("t1_count", px_q.size(), 8);
    if (px_q.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        check($sformatf("t1_px%0d", i),   px_q[i],  exp_t1[i]);
        check($sformatf("t1_last%0d", i), lst_q[i], (i == 7) ? 1 : 0);
      end
    end
    check("t1_interval",   pix_int,  3);
    check("t1_gap",        gap_meas, 2161);
    check("t1_busy_at_fd", bus.busy, 0);

    // T2: brightness 127, changed to 255 mid-frame (must not apply yet)
    write_led(4'd0, 24'hFF8001);
    bus.brightness = 8'd127;
    pulse_req();
    bus.brightness = 8'd255;
    wait_frame(0, -1, 4'd0, 24'd0);
    check("t2_count", px_q.size(), 8);
    if (px_q.size() == 8) begin
      check("t2_px0", px_q[0], 24'h407F00);
      check("t2_px1", px_q[1], 24'h110819);
    end

    // T3: backpressure for 50 cycles
    bus.pix_ready = 1'b0;
    pulse_req();
    wait_valid("t3_valid");
    held = bus.pix_data;
    check("t3_first", held, 24'h80FF01);
    stable = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!bus.pix_valid || bus.pix_data !== held || bus.pix_last !== 1'b0) stable = 1'b0;
    end
    check("t3_stable", stable, 1);
    bus.pix_ready = 1'b1;
    wait_frame(0, -1, 4'd0, 24'd0);
    check("t3_count", px_q.size(), 8);
    if (px_q.size() == 8) begin
      check("t3_px0", px_q[0], 24'h80FF01);
      check("t3_px1", px_q[1], 24'h221133);
    end

    // T4: three requests during a frame coalesce into one extra frame
    pulse_req();
    wait_frame(3, -1, 4'd0, 24'd0);
    check("t4_count_a", px_q.size(), 8);
    @(negedge clk);
    check("t4_restart", bus.busy, 1);
    wait_frame(0, -1, 4'd0, 24'd0);
    check("t4_count_b", px_q.size(), 8);
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.pix_valid || bus.busy) cnt++;
    end
    check("t4_no_third", cnt, 0);

    // T5: out-of-range writes ignored; mid-frame write to a later index shows up
    write_led(4'd9,  24'hABCDEF);
    write_led(4'd15, 24'h123456);
    pulse_req();
    wait_frame(0, 2, 4'd5, 24'h0A0B0C);
    check("t5_count", px_q.size(), 8);
    if (px_q.size() == 8) begin
      check("t5_px0", px_q[0], 24'h80FF01);
      check("t5_px1", px_q[1], 24'h221133);
      check("t5_px5", px_q[5], 24'h0B0A0C);
      check("t5_px7", px_q[7], 24'hEF7765);
    end

    // T6: async reset while presenting
    bus.pix_ready = 1'b0;
    pulse_req();
    wait_valid("t6_valid");
    check("t6_pre_data", bus.pix_data, 24'h80FF01);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_busy",      bus.busy,       0);
    check("t6_pix_valid", bus.pix_valid,  0);
    check("t6_pix_data",  bus.pix_data,   0);
    check("t6_pix_last",  bus.pix_last,   0);
    check("t6_fdone",     bus.frame_done, 0);
    @(negedge clk);
    rst_n         = 1'b1;
    bus.pix_ready = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.busy || bus.pix_valid) cnt++;
    end
    check("t6_idle", cnt, 0);
    pulse_req();
    wait_frame(0, -1, 4'd0, 24'd0);
    check("t6_count", px_q.size(), 8);
    if (px_q.size() == 8) begin
      check("t6_px0", px_q[0], 24'h80FF01);
      check("t6_px5", px_q[5], 24'h0B0A0C);
      check("t6_px7", px_q[7], 24'hEF7765);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
